// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared encodings, region codes and VRAM limits for the graphics write port
// Contents: size encodings, region codes, VRAM offset thresholds, posted-write entry type,
//           writer FSM state type, BG byte-write limit helper.
package gfx_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] REG_PAL  = 4'h5;
    localparam logic [3:0] REG_VRAM = 4'h6;

    localparam logic [16:0] VRAM_MIRROR_BASE = 17'h18000;
    localparam logic [16:0] BG_LIMIT_BITMAP  = 17'h14000;
    localparam logic [16:0] BG_LIMIT_TILE    = 17'h10000;

    typedef struct packed {
        logic [27:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } wentry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HI   = 1'b1
    } wstate_t;

    // Bitmap modes 3-5 extend the BG area into the first 16 KB of the OBJ block.
    function automatic logic [16:0] bg_limit(input logic [2:0] mode);
        return (mode == 3'd3 || mode == 3'd4 || mode == 3'd5) ? BG_LIMIT_BITMAP : BG_LIMIT_TILE;
    endfunction

endpackage

// File: rtl/gfx_wfifo.sv
// rtl/gfx_wfifo.sv - posted-write FIFO with fall-through of a push into an empty FIFO
// Ports: clk, clrn (sync active-low flush), push/push_data, pop, head (front entry, or
//        push_data when empty), full, empty.
import gfx_pkg::*;

module gfx_wfifo #(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    clrn,
    input  logic    push,
    input  wentry_t push_data,
    input  logic    pop,
    output wentry_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    wentry_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // When empty, the entry being pushed is presented directly so a push+pop in the
    // same cycle passes straight through; count stays put and both pointers advance.
    assign head = empty ? push_data : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gfx_mem_writer.sv
// rtl/gfx_mem_writer.sv - posted CPU/DMA write port into VRAM and palette RAM
// Ports: clk, clrn; wr_req/wr_ready/wr_addr/wr_size/wr_data bus side; dispcnt mode input;
//        vram_we/vram_waddr/vram_wdata and pal_we/pal_waddr/pal_wdata halfword strobes;
//        dropped pulse; idle status.
import gfx_pkg::*;

module gfx_mem_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int VRAM_AW    = 16,
    parameter int PAL_AW     = 9
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               wr_req,
    output logic               wr_ready,
    input  logic [31:0]        wr_addr,
    input  logic [1:0]         wr_size,
    input  logic [31:0]        wr_data,
    input  logic [15:0]        dispcnt,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_waddr,
    output logic [15:0]        vram_wdata,
    output logic               pal_we,
    output logic [PAL_AW-1:0]  pal_waddr,
    output logic [15:0]        pal_wdata,
    output logic               dropped,
    output logic               idle
);

    wstate_t     state;
    wentry_t     head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    logic [27:0] addr_al;
    logic [16:0] off;
    logic [16:0] off_m;
    logic [15:0] v_idx;
    logic [8:0]  p_idx;
    logic [15:0] lo_data;
    logic        is_pal;
    logic        is_vram;
    logic        drop;

    logic        hi_pal;
    logic [15:0] hi_vidx;
    logic [8:0]  hi_pidx;
    logic [15:0] hi_data;

    assign wr_ready = !full;
    assign push     = wr_req && !full;
    assign pop      = (state == ST_IDLE) && (!empty || push);
    assign idle     = empty && (state == ST_IDLE);

    gfx_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (push),
        .push_data ('{addr: wr_addr[27:0], size: wr_size, data: wr_data}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Decode of the entry at the front of the queue.
    always_comb begin
        addr_al = head.addr;
        if (head.size == SZ_WORD) begin
            addr_al[1:0] = 2'b00;
        end else if (head.size == SZ_HALF) begin
            addr_al[0] = 1'b0;
        end
        off     = addr_al[16:0];
        off_m   = (off >= VRAM_MIRROR_BASE) ? off - 17'h08000 : off;
        v_idx   = off_m[16:1];
        p_idx   = addr_al[9:1];
        lo_data = (head.size == SZ_BYTE) ? {head.data[7:0], head.data[7:0]} : head.data[15:0];
        is_pal  = (addr_al[27:24] == REG_PAL);
        is_vram = (addr_al[27:24] == REG_VRAM);
        // Byte writes into OBJ VRAM are ignored by the hardware, as are unknown regions.
        drop    = (head.size == 2'd3) || !(is_pal || is_vram) ||
                  (is_vram && head.size == SZ_BYTE && off_m >= bg_limit(dispcnt[2:0]));
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state      <= ST_IDLE;
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
            pal_we     <= 1'b0;
            pal_waddr  <= '0;
            pal_wdata  <= '0;
            dropped    <= 1'b0;
            hi_pal     <= 1'b0;
            hi_vidx    <= '0;
            hi_pidx    <= '0;
            hi_data    <= '0;
        end else begin
            vram_we <= 1'b0;
            pal_we  <= 1'b0;
            dropped <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (drop) begin
                            dropped <= 1'b1;
                        end else begin
                            if (is_pal) begin
                                pal_we    <= 1'b1;
                                pal_waddr <= PAL_AW'(p_idx);
                                pal_wdata <= lo_data;
                            end else begin
                                vram_we    <= 1'b1;
                                vram_waddr <= VRAM_AW'(v_idx);
                                vram_wdata <= lo_data;
                            end
                            if (head.size == SZ_WORD) begin
                                state   <= ST_HI;
                                hi_pal  <= is_pal;
                                hi_vidx <= v_idx + 16'd1;
                                hi_pidx <= p_idx + 9'd1;
                                hi_data <= head.data[31:16];
                            end
                        end
                    end
                end
                ST_HI: begin
                    if (hi_pal) begin
                        pal_we    <= 1'b1;
                        pal_waddr <= PAL_AW'(hi_pidx);
                        pal_wdata <= hi_data;
                    end else begin
                        vram_we    <= 1'b1;
                        vram_waddr <= VRAM_AW'(hi_vidx);
                        vram_wdata <= hi_data;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wr_addr[31:28], dispcnt[15:3], addr_al[23:17]};

endmodule

// File: tb/tb_gfx_mem_writer.sv
// tb/tb_gfx_mem_writer.sv - directed self-checking bench for gfx_mem_writer
module tb_gfx_mem_writer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clrn;
    logic        wr_req;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic [31:0] wr_data;
    logic [15:0] dispcnt;
    logic        vram_we;
    logic [15:0] vram_waddr;
    logic [15:0] vram_wdata;
    logic        pal_we;
    logic [8:0]  pal_waddr;
    logic [15:0] pal_wdata;
    logic        dropped;
    logic        idle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gfx_mem_writer #(.FIFO_DEPTH(DEPTH), .VRAM_AW(16), .PAL_AW(9)) dut (
        .clk(clk), .clrn(clrn), .wr_req(wr_req), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_size(wr_size), .wr_data(wr_data), .dispcnt(dispcnt), .vram_we(vram_we),
        .vram_waddr(vram_waddr), .vram_wdata(vram_wdata), .pal_we(pal_we),
        .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .dropped(dropped), .idle(idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of accepted writes ----------------
    typedef struct {
        logic [27:0] a;
        logic [1:0]  s;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        e_vwe = 0, e_pwe = 0, e_drop = 0;
    logic [15:0] e_va = 0, e_vd = 0, e_pd = 0;
    logic [8:0]  e_pa = 0;
    logic        m_ready = 1, m_idle = 1;
    logic        hi_pend = 0, hi_pal = 0;
    int          hi_idx = 0;
    logic [15:0] hi_data = 0;

    task automatic emit(input logic pal, input int idx, input logic [15:0] d);
        if (pal) begin
            e_pwe = 1; e_pa = idx[8:0]; e_pd = d;
        end else begin
            e_vwe = 1; e_va = idx[15:0]; e_vd = d;
        end
    endtask

    task automatic model_entry(input ent_t e);
        logic [27:0] a;
        int region, off, limit, idx, mode;
        logic [15:0] lo;
        a = e.a;
        if (e.s == 2) a[1:0] = 2'b00;
        if (e.s == 1) a[0] = 1'b0;
        region = int'(a[27:24]);
        mode   = int'(dispcnt[2:0]);
        limit  = (mode >= 3 && mode <= 5) ? 'h14000 : 'h10000;
        lo     = (e.s == 0) ? {e.d[7:0], e.d[7:0]} : e.d[15:0];
        if (e.s == 3 || (region != 5 && region != 6)) begin
            e_drop = 1;
            return;
        end
        if (region == 5) begin
            idx = int'(a[9:1]);
        end else begin
            off = int'(a[16:0]);
            if (off >= 'h18000) off = off - 'h8000;
            if (e.s == 0 && off >= limit) begin
                e_drop = 1;
                return;
            end
            idx = off / 2;
        end
        emit(region == 5, idx, lo);
        if (e.s == 2) begin
            hi_pend = 1; hi_pal = (region == 5); hi_idx = idx + 1; hi_data = e.d[31:16];
        end
    endtask

    always @(posedge clk) begin
        if (!clrn) begin
            q.delete();
            hi_pend = 0;
            e_vwe = 0; e_pwe = 0; e_drop = 0;
            e_va = 0; e_vd = 0; e_pa = 0; e_pd = 0;
        end else begin
            e_vwe = 0; e_pwe = 0; e_drop = 0;
            if (wr_req && m_ready) q.push_back('{a: wr_addr[27:0], s: wr_size, d: wr_data});
            if (hi_pend) begin
                emit(hi_pal, hi_idx, hi_data);
                hi_pend = 0;
            end else if (q.size() > 0) begin
                model_entry(q.pop_front());
            end
        end
        m_ready = (q.size() < DEPTH);
        m_idle  = (q.size() == 0) && !hi_pend;
    end

    logic chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_vram_we", vram_we, e_vwe);
            chk("cyc_pal_we", pal_we, e_pwe);
            chk("cyc_dropped", dropped, e_drop);
            chk("cyc_wr_ready", wr_ready, m_ready);
            chk("cyc_idle", idle, m_idle);
            chk("cyc_vram_waddr", vram_waddr, e_va);
            chk("cyc_vram_wdata", vram_wdata, e_vd);
            chk("cyc_pal_waddr", pal_waddr, e_pa);
            chk("cyc_pal_wdata", pal_wdata, e_pd);
        end
    end

    int vcnt = 0;
    always @(negedge clk) if (vram_we === 1'b1) vcnt++;

    // ---------------- stimulus ----------------
    task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        wr_addr = a; wr_size = s; wr_data = d; wr_req = 1;
        @(negedge clk);
        wr_req = 0;
        #1;
    endtask

    logic saw_low;
    task automatic burst(input int n, input logic [31:0] base);
        int i;
        int guard;
        logic r;
        i = 0; guard = 0; saw_low = 0;
        @(negedge clk);
        wr_addr = base; wr_size = 2'd2; wr_data = {16'hA000, 16'h0000}; wr_req = 1;
        while (i < n && guard < 200) begin
            r = wr_ready;
            if (!r) saw_low = 1;
            @(negedge clk);
            guard++;
            if (r) begin
                i++;
                if (i < n) begin
                    wr_addr = base + 32'(4 * i);
                    wr_data = {16'hA000 + 16'(i), 16'(i)};
                end else begin
                    wr_req = 0;
                end
            end
        end
        wr_req = 0;
        chk("burst_accepts", i, n);
    endtask

    task automatic wait_idle;
        int k;
        k = 0;
        while (idle !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wait_idle_timeout", idle, 1'b1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        clrn = 0; wr_req = 0; wr_addr = 0; wr_size = 0; wr_data = 0; dispcnt = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_vram_we", vram_we, 0);
        chk("rst_pal_we", pal_we, 0);
        chk("rst_vram_waddr", vram_waddr, 0);
        clrn = 1;
        chk_en = 1;

        // word into VRAM: low half then high half
        issue(32'h0600_0004, 2'd2, 32'h1234_5678);
        chk("word_lo_we", vram_we, 1);
        chk("word_lo_addr", vram_waddr, 16'h0002);
        chk("word_lo_data", vram_wdata, 16'h5678);
        @(negedge clk); #1;
        chk("word_hi_we", vram_we, 1);
        chk("word_hi_addr", vram_waddr, 16'h0003);
        chk("word_hi_data", vram_wdata, 16'h1234);
        @(negedge clk); #1;
        chk("word_idle", idle, 1);
        chk("word_done_we", vram_we, 0);

        // bitmap-mode byte writes
        dispcnt = 16'h0003;
        issue(32'h0600_9001, 2'd0, 32'h0000_00AB);
        chk("byte_bg_we", vram_we, 1);
        chk("byte_bg_addr", vram_waddr, 16'h4800);
        chk("byte_bg_data", vram_wdata, 16'hABAB);
        issue(32'h0601_4000, 2'd0, 32'h0000_00CD);
        chk("byte_obj3_drop", dropped, 1);
        chk("byte_obj3_we", vram_we, 0);
        dispcnt = 16'h0000;
        issue(32'h0601_0000, 2'd0, 32'h0000_00EF);
        chk("byte_obj0_drop", dropped, 1);

        // palette writes
        issue(32'h0500_01FE, 2'd1, 32'h0000_7FFF);
        chk("pal_half_we", pal_we, 1);
        chk("pal_half_addr", pal_waddr, 9'h0FF);
        chk("pal_half_data", pal_wdata, 16'h7FFF);
        issue(32'h0500_0003, 2'd0, 32'h0000_001F);
        chk("pal_byte_addr", pal_waddr, 9'h001);
        chk("pal_byte_data", pal_wdata, 16'h1F1F);

        // mirror, unknown region, size 3, palette word
        issue(32'h0601_C000, 2'd1, 32'h0000_1357);
        chk("mirror_addr", vram_waddr, 16'hA000);
        issue(32'h0300_0000, 2'd1, 32'h0000_2468);
        chk("bad_region_drop", dropped, 1);
        chk("bad_region_we", vram_we | pal_we, 0);
        issue(32'h0600_0010, 2'd3, 32'h0000_1111);
        chk("size3_drop", dropped, 1);
        issue(32'h0500_0206, 2'd2, 32'hBEEF_CAFE);
        chk("pal_word_lo_addr", pal_waddr, 9'h102);
        @(negedge clk); #1;
        chk("pal_word_hi_addr", pal_waddr, 9'h103);
        chk("pal_word_hi_data", pal_wdata, 16'hBEEF);
        wait_idle();

        // long word burst fills the FIFO
        vcnt = 0;
        burst(10, 32'h0600_0100);
        chk("burst_ready_dropped", saw_low, 1);
        wait_idle();
        chk("burst_strobes", vcnt, 20);
        chk("burst_last_addr", vram_waddr, 16'h0080 + 16'd19);
        chk("burst_last_data", vram_wdata, 16'hA009);

        // reset while the high half is pending and two entries wait
        burst(5, 32'h0600_0400);
        chk("pre_rst_busy", idle, 0);
        clrn = 0;
        @(negedge clk); #1;
        chk("midrst_vram_we", vram_we, 0);
        chk("midrst_ready", wr_ready, 1);
        chk("midrst_idle", idle, 1);
        clrn = 1;
        vcnt = 0;
        repeat (8) @(negedge clk);
        #1;
        chk("midrst_no_strobes", vcnt, 0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
